// File: rtl/cla_pkg.sv
// Shared encodings for the serial shift sequencer and its staging neighbours.
package cla_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/seq_shift_reg_dff_ar.sv
// Single-bit storage element with asynchronous active-high reset to 0.
module dff_ar (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end

endmodule

// File: rtl/seq_shift_reg.sv
// WIDTH-bit register that loads a word on start and shifts it serially
// amt times (left, logical right or arithmetic right), then pulses done.
module seq_shift_reg
   import cla_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic [AMT_W-1:0] amt,
   input  logic             dir,
   input  logic             arith,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic             ser_out
);

   localparam int NB = WIDTH + AMT_W + 6;

   logic [WIDTH-1:0] q_d,   q_q;
   logic [AMT_W-1:0] cnt_d, cnt_q;
   logic [1:0]       state_q;
   state_e           state_d;
   logic             dir_d,   dir_q;
   logic             arith_d, arith_q;
   logic             ser_d,   ser_q;
   logic             done_d,  done_q;

   logic [NB-1:0]    flop_d, flop_q;

   // Every state bit lives in its own dff_ar; pack/unpack around the array.
   assign flop_d = {q_d, cnt_d, state_d, dir_d, arith_d, ser_d, done_d};
   assign {q_q, cnt_q, state_q, dir_q, arith_q, ser_q, done_q} = flop_q;

   for (genvar i = 0; i < NB; i++) begin : g_bit
      dff_ar u_dff (
         .clk (clk),
         .rst (rst),
         .d   (flop_d[i]),
         .q   (flop_q[i])
      );
   end

   always_comb begin
      q_d     = q_q;
      cnt_d   = cnt_q;
      state_d = ST_IDLE;
      dir_d   = dir_q;
      arith_d = arith_q;
      ser_d   = ser_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
            if (start) begin
               q_d     = din;
               cnt_d   = amt;
               dir_d   = dir;
               arith_d = arith;
               ser_d   = 1'b0;
               state_d = (amt != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (dir_q == DIR_L) begin
               q_d   = {q_q[WIDTH-2:0], 1'b0};
               ser_d = q_q[WIDTH-1];
            end else begin
               q_d   = {arith_q & q_q[WIDTH-1], q_q[WIDTH-1:1]};
               ser_d = q_q[0];
            end
            cnt_d   = cnt_q - AMT_W'(1);
            state_d = (cnt_q == AMT_W'(1)) ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // done mirrors "state is DONE" so the pulse is exactly one cycle wide
      done_d = (state_d == ST_DONE);
   end

   assign ready   = (state_q == ST_IDLE);
   assign done    = done_q;
   assign q       = q_q;
   assign ser_out = ser_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
// Scoreboard bench for seq_shift_reg (WIDTH=8): driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_shift_reg;
   import cla_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] din;
   logic [2:0] amt;
   logic       dir;
   logic       arith;
   logic       ready;
   logic       done;
   logic [7:0] q;
   logic       ser_out;

   typedef struct {
      logic [7:0] q;
      logic       ser;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   since      = 0;
   int   cyc        = 0;
   int   last_acc   = -1;
   bit   hold_mode  = 1'b0;
   bit   prev_done  = 1'b0;

   seq_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .din     (din),
      .amt     (amt),
      .dir     (dir),
      .arith   (arith),
      .ready   (ready),
      .done    (done),
      .q       (q),
      .ser_out (ser_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (rst) begin
         since     = 0;
         prev_done = 1'b0;
      end else begin
         since++;
         if (done) begin
            chk("done_pulse_width", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result_q", 32'(q), 32'(e.q));
               chk("result_ser_out", 32'(ser_out), 32'(e.ser));
               chk("latency", 32'(since), 32'(e.lat));
            end
         end
         if (start && ready) begin
            if (hold_mode && last_acc >= 0)
               chk("accept_interval", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            since    = 0;
         end
         prev_done = done;
      end
      cyc++;
   end

   // Entered and left at posedge+#2 so inputs never move near either edge.
   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (!ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic dr,
                        input logic ar, input logic [7:0] eq, input logic es, input bit push);
      exp_t e;
      wait_ready();
      din   = d;
      amt   = a;
      dir   = dr;
      arith = ar;
      start = 1'b1;
      if (push) begin
         e.q   = eq;
         e.ser = es;
         e.lat = int'(a) + 1;
         sb.push_back(e);
      end
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hold_din [3];
      logic [7:0] hold_q   [3];
      logic       hold_ser [3];
      hold_din = '{8'h81, 8'h40, 8'hC3};
      hold_q   = '{8'h02, 8'h80, 8'h86};
      hold_ser = '{1'b1,  1'b0,  1'b1};

      rst = 1'b1; start = 1'b0; din = '0; amt = '0; dir = DIR_L; arith = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      // Left shift by 3 with intermediate values
      issue(8'h96, 3'd3, DIR_L, 1'b0, 8'hB0, 1'b0, 1'b1);
      chk("load_q", 32'(q), 32'h96);
      @(posedge clk); #2;
      chk("shl_step1", 32'(q), 32'h2C);
      @(posedge clk); #2;
      chk("shl_step2", 32'(q), 32'h58);

      // Right shifts, arithmetic then logical
      issue(8'h96, 3'd2, DIR_R, 1'b1, 8'hE5, 1'b1, 1'b1);
      issue(8'h96, 3'd2, DIR_R, 1'b0, 8'h25, 1'b1, 1'b1);

      // amt=0: ready low for exactly one cycle
      issue(8'hA5, 3'd0, DIR_L, 1'b0, 8'hA5, 1'b0, 1'b1);
      chk("amt0_ready_low", 32'(ready), 32'd0);
      @(posedge clk); #2;
      chk("amt0_ready_back", 32'(ready), 32'd1);

      // Full-range shifts, and arith must not alter a left shift
      issue(8'h01, 3'd7, DIR_L, 1'b0, 8'h80, 1'b0, 1'b1);
      issue(8'hFF, 3'd5, DIR_R, 1'b0, 8'h07, 1'b1, 1'b1);
      issue(8'hC1, 3'd2, DIR_L, 1'b1, 8'h04, 1'b1, 1'b1);

      // Arithmetic right by 7, inputs disturbed during the sequence
      issue(8'h80, 3'd7, DIR_R, 1'b1, 8'hFF, 1'b0, 1'b1);
      din = 8'h00; amt = 3'd3; dir = DIR_L; arith = 1'b0;

      // start held high continuously with amt=1
      wait_ready();
      hold_mode = 1'b1;
      last_acc  = -1;
      amt = 3'd1; dir = DIR_L; arith = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         din   = hold_din[i];
         e.q   = hold_q[i];
         e.ser = hold_ser[i];
         e.lat = 2;
         sb.push_back(e);
         @(posedge clk); #2;
         din = 8'h5A;
         wait_ready();
      end
      start = 1'b0;
      hold_mode = 1'b0;
      @(posedge clk); #2;

      // Asynchronous reset in the middle of a shift sequence
      issue(8'hFF, 3'd7, DIR_L, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk); #1;
      chk("pre_rst_busy", 32'(ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst_q", 32'(q), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ser_out", 32'(ser_out), 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk); #2;

      // Post-reset sequence still works
      issue(8'h3C, 3'd1, DIR_R, 1'b0, 8'h1E, 1'b0, 1'b1);

      for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
